// File: rtl/timer_pkg.sv
// Shared register-map constants and control-register layout for the MMIO timer.
package timer_pkg;

   localparam logic [1:0] CTRL_OFS  = 2'd0;
   localparam logic [1:0] COUNT_OFS = 2'd1;
   localparam logic [1:0] CMP_OFS   = 2'd2;
   localparam logic [1:0] STAT_OFS  = 2'd3;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_AR_BIT  = 1;
   localparam int unsigned CTRL_IE_BIT  = 2;
   localparam int unsigned CTRL_PSC_LSB = 16;

   typedef struct packed {
      logic [15:0] prescale;
      logic        irq_en;
      logic        auto_reload;
      logic        en;
   } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: one tick every prescale+1 enabled cycles. `en` is the enable value
// that CTRL will hold after the current edge, so a disabling write clears the count at that edge.
module timer_prescaler #(
   parameter int unsigned PSC_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [PSC_W-1:0] prescale,
   output logic             tick
);

   logic [PSC_W-1:0] psc_cnt;
   logic             en_q;

   assign tick = en_q && (psc_cnt == prescale);

   // en_q mirrors the committed EN bit; the count stays at 0 on the enabling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q    <= 1'b0;
         psc_cnt <= '0;
      end else begin
         en_q <= en;
         if (!en || !en_q || tick)
            psc_cnt <= '0;
         else
            psc_cnt <= psc_cnt + PSC_W'(1);
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, auto-reload and level irq.
module mmio_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int unsigned PSC_W     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        hit,
   output logic        irq
);

   localparam logic [15:0] PSC_MASK = 16'((32'd1 << PSC_W) - 32'd1);

   ctrl_t       ctrl;
   ctrl_t       ctrl_wdata;
   logic [31:0] count;
   logic [31:0] compare;
   logic        match;
   logic [1:0]  sel;
   logic        wr, ctrl_wr, count_wr, cmp_wr, stat_wr;
   logic        tick, is_match, en_next;
   logic        unused_addr_bits;

   assign hit      = (data_addr[31:4] == BASE_ADDR[31:4]);
   assign sel      = data_addr[3:2];
   assign wr       = mem_write & hit;
   assign ctrl_wr  = wr && (sel == CTRL_OFS);
   assign count_wr = wr && (sel == COUNT_OFS);
   assign cmp_wr   = wr && (sel == CMP_OFS);
   assign stat_wr  = wr && (sel == STAT_OFS);
   assign unused_addr_bits = ^data_addr[1:0];

   always_comb begin
      ctrl_wdata             = '0;
      ctrl_wdata.prescale    = write_data[CTRL_PSC_LSB +: 16] & PSC_MASK;
      ctrl_wdata.irq_en      = write_data[CTRL_IE_BIT];
      ctrl_wdata.auto_reload = write_data[CTRL_AR_BIT];
      ctrl_wdata.en          = write_data[CTRL_EN_BIT];
   end

   assign en_next = ctrl_wr ? write_data[CTRL_EN_BIT] : ctrl.en;

   timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .en       (en_next),
      .prescale (ctrl.prescale[PSC_W-1:0]),
      .tick     (tick)
   );

   assign is_match = tick && (count == compare);

   // A CPU COUNT write overrides the tick; match is still judged on the old COUNT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl    <= '0;
         count   <= '0;
         compare <= '1;
         match   <= 1'b0;
      end else begin
         if (ctrl_wr)
            ctrl <= ctrl_wdata;
         if (cmp_wr)
            compare <= write_data;
         if (count_wr)
            count <= write_data;
         else if (tick)
            count <= (is_match && ctrl.auto_reload) ? '0 : count + 32'd1;
         if (is_match)
            match <= 1'b1;
         else if (stat_wr && write_data[0])
            match <= 1'b0;
      end
   end

   assign irq = match & ctrl.irq_en;

   always_comb begin
      read_data = '0;
      if (hit) begin
         case (sel)
            CTRL_OFS:  read_data = {ctrl.prescale, 13'd0, ctrl.irq_en, ctrl.auto_reload, ctrl.en};
            COUNT_OFS: read_data = count;
            CMP_OFS:   read_data = compare;
            STAT_OFS:  read_data = {31'd0, match};
            default:   read_data = '0;
         endcase
      end
   end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral that acts as a responder on the CPU data bus (mem_write, data_addr, write_data, read_data).
- Sits beside dataMemory at the top level. Top muxes read_data from this block when hit=1.
- Provides a prescaled 32-bit up-counter, a compare match flag with optional auto-reload, and a level interrupt output.
- Reads are combinational, which single-cycle CPU timing requires. Writes commit on the rising clock edge.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of the 16-byte register window; low 4 bits must be zero.
- PSC_W, 16, prescaler width in bits; legal range 1..16.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- mem_write  input  1  CPU store strobe, sampled on the rising edge of clk
- data_addr  input  32  CPU data address
- write_data  input  32  CPU store data
- read_data  output  32  register read data; combinational
- hit  output  1  data_addr falls in this block's window; combinational
- irq  output  1  interrupt request, level-sensitive

Behaviour:
- Decode:
  - hit = (data_addr[31:4] == BASE_ADDR[31:4]).
  - Register select uses data_addr[3:2]; data_addr[1:0] is ignored.
  - A write occurs only when mem_write & hit.
- Register map:
  - 0x0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[16+PSC_W-1:16] PRESCALE. All other bits read 0 and ignore writes.
  - 0x4 COUNT: R/W.
  - 0x8 COMPARE: R/W.
  - 0xC STATUS: bit0 MATCH, write-1-to-clear; bits[31:1] read 0.
- read_data = hit ? selected register : 32'h0. Same-cycle combinational path; no read side effects.
- Reset (async, immediate): CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, psc_cnt=0. Therefore irq=0, and read_data follows decode.
- Prescaler:
  - psc_cnt is PSC_W bits wide.
  - While EN=0, psc_cnt is held at 0 and no tick occurs.
  - While EN=1, tick = (psc_cnt == PRESCALE). On tick, psc_cnt<=0; otherwise psc_cnt<=psc_cnt+1.
  - PRESCALE=0 gives a tick every cycle. PRESCALE=P gives one tick per P+1 cycles.
- Counter on tick:
  - If COUNT==COMPARE: MATCH<=1, and COUNT <= AUTO_RELOAD ? 0 : COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Wraps modulo 2^32 (32'hFFFF_FFFF -> 0).
- First tick timing: after a write of EN=1 at edge k (psc_cnt=0), the first tick is evaluated in the cycle ending at edge k+1+P.
- irq = MATCH & IRQ_EN, driven from registers (glitch-free). Clearing IRQ_EN masks irq but leaves MATCH unchanged.
- Simultaneous events:
  - CPU write to COUNT in a tick cycle: the written value wins; the tick's increment and reload are discarded. A match is still evaluated on the pre-write COUNT.
  - STATUS write-1-to-clear in the same cycle as a match: set wins, so MATCH stays 1.
  - CTRL write that changes PRESCALE while EN=1: takes effect next cycle. If psc_cnt > new PRESCALE, psc_cnt runs up to 2^PSC_W-1, wraps to 0, then resumes normally. This is documented, not an error.
  - CTRL write setting EN=0: psc_cnt is cleared at that edge; COUNT and MATCH are retained.
  - COMPARE write: the new value is used from the next cycle.
- Reset asserted mid-count: all state returns to reset values immediately; no tick completes.

Decomposition:
- Shared package timer_pkg:
  - Register offset constants: CTRL_OFS=2'd0, COUNT_OFS=2'd1, CMP_OFS=2'd2, STAT_OFS=2'd3.
  - CTRL bit-index constants.
  - Packed struct ctrl_t {prescale, irq_en, auto_reload, en}.
- One natural sub-module: timer_prescaler (clk, reset, en, prescale, tick). The register file, decode and counter stay in mmio_timer.

Test Plan:
- Reset/readback: assert reset mid-run -> COUNT reads 0, COMPARE reads 32'hFFFF_FFFF, STATUS reads 0, irq=0. Read at 0xFFFF_1000 -> hit=0, read_data=0.
- Prescale: write COMPARE=5, then CTRL=0x0003_0001 (PRESCALE=3, EN). After 24 cycles -> COUNT=6, MATCH=1 latched at the tick where COUNT was 5, irq=0 because IRQ_EN=0.
- Auto-reload/irq: CTRL=0x0000_0007, COMPARE=2 -> COUNT sequence 1,2,0,1,2,0. irq rises the cycle after the first COUNT=2 tick and stays high. Write STATUS=1 -> irq drops next cycle.
- Wrap: COUNT=32'hFFFF_FFFE, EN=1, PRESCALE=0, COMPARE=7 -> reads FFFF_FFFF then 0 then 1; MATCH stays 0.
- Collision: write COUNT=100 in the same cycle as a tick -> next read is 100, not 101. Issue STATUS clear in a cycle where a match occurs -> MATCH remains 1.
- Async reset: assert reset between clock edges while irq=1 -> irq and all registers clear before the next edge.
